// File: rtl/store_buffer_if.sv
// Store buffer port bundle: store enqueue, ROB commit/flush, memory write port and load-forward lookup.
// The master side is the store unit / ROB / memory environment; the slave side is the buffer.
interface store_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int DEPTH      = 8
);
  logic                      store_valid;
  logic [ADDR_WIDTH-1:0]     store_waddr;
  logic [DATA_WIDTH-1:0]     store_wdata;
  logic [2:0]                store_funct3;
  logic [ROB_WIDTH-1:0]      store_rob_id;
  logic                      full;
  logic [$clog2(DEPTH):0]    count;
  logic                      commit_valid;
  logic [ROB_WIDTH-1:0]      commit_rob_id;
  logic                      flush;
  logic                      mem_wen;
  logic [ADDR_WIDTH-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [3:0]                mem_wstrb;
  logic                      mem_ready;
  logic [ADDR_WIDTH-1:0]     ld_addr;
  logic [3:0]                ld_strb;
  logic                      ld_fwd_hit;
  logic [DATA_WIDTH-1:0]     ld_fwd_data;
  logic                      ld_fwd_stall;

  modport master (
    output store_valid, store_waddr, store_wdata, store_funct3, store_rob_id,
    output commit_valid, commit_rob_id, flush, mem_ready, ld_addr, ld_strb,
    input  full, count, mem_wen, mem_waddr, mem_wdata, mem_wstrb,
    input  ld_fwd_hit, ld_fwd_data, ld_fwd_stall
  );

  modport slave (
    input  store_valid, store_waddr, store_wdata, store_funct3, store_rob_id,
    input  commit_valid, commit_rob_id, flush, mem_ready, ld_addr, ld_strb,
    output full, count, mem_wen, mem_waddr, mem_wdata, mem_wstrb,
    output ld_fwd_hit, ld_fwd_data, ld_fwd_stall
  );
endinterface

// File: rtl/store_buffer.sv
// Post-execute store buffer: holds stores until ROB retirement, drains them in order with byte strobes.
// Define STORE_BUFFER_FWD_EN to forward buffered data to loads; otherwise any word match stalls the load.
// Valid/ready: a memory write transfers on a rising edge where mem_wen && mem_ready; while mem_wen is
// high and mem_ready low the write address/data/strobe hold. Enqueue transfers when store_valid && !full.
module store_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int DEPTH      = 8
) (
  input logic         clk,
  input logic         rst,
  store_buffer_if.slave sb
);
  localparam int PW = $clog2(DEPTH);

  typedef logic [PW-1:0] idx_t;
  typedef logic [PW:0]   ptr_t;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      cmt_q, cmt_d;
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  logic [ADDR_WIDTH-3:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [3:0]            strb_q [DEPTH];
  logic [ROB_WIDTH-1:0]  rob_q  [DEPTH];

  idx_t head_idx, tail_idx, cmt_idx;
  logic cmt_hit, drain_fire, enq_fire;
  logic [3:0] enq_strb;
  ptr_t n_cmt;

  function automatic idx_t age_idx(input idx_t base, input int unsigned off);
    return base + idx_t'(off);
  endfunction

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];

  assign sb.full  = (head_idx == tail_idx) && (head_q[PW] != tail_q[PW]);
  assign sb.count = tail_q - head_q;

  assign sb.mem_wen   = valid_q[head_idx] && cmt_q[head_idx];
  assign sb.mem_waddr = sb.mem_wen ? {addr_q[head_idx], 2'b00} : '0;
  assign sb.mem_wdata = sb.mem_wen ? data_q[head_idx] : '0;
  assign sb.mem_wstrb = sb.mem_wen ? strb_q[head_idx] : '0;

  assign drain_fire = sb.mem_wen && sb.mem_ready;
  assign enq_fire   = sb.store_valid && !sb.full && !sb.flush;

  always_comb begin
    enq_strb = 4'b0000;
    case (sb.store_funct3)
      3'b000:  enq_strb = 4'b0001 << sb.store_waddr[1:0];
      3'b001:  enq_strb = sb.store_waddr[1] ? 4'b1100 : 4'b0011;
      3'b010:  enq_strb = 4'b1111;
      default: enq_strb = 4'b0000;
    endcase
  end

  // Oldest matching uncommitted entry takes the commit, so a reused tag retires in program order.
  always_comb begin
    cmt_hit = 1'b0;
    cmt_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (sb.commit_valid && !cmt_hit &&
          valid_q[age_idx(head_idx, i)] && !cmt_q[age_idx(head_idx, i)] &&
          rob_q[age_idx(head_idx, i)] == sb.commit_rob_id) begin
        cmt_hit = 1'b1;
        cmt_idx = age_idx(head_idx, i);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    cmt_d   = cmt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    n_cmt   = '0;
    if (cmt_hit) cmt_d[cmt_idx] = 1'b1;
    // Committed count includes this cycle's commit and the head being drained, so flush keeps both.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      n_cmt = n_cmt + ptr_t'(valid_q[i] & cmt_d[i]);
    end
    if (drain_fire) begin
      valid_d[head_idx] = 1'b0;
      cmt_d[head_idx]   = 1'b0;
      head_d            = head_q + ptr_t'(1);
    end
    if (sb.flush) begin
      tail_d  = head_q + n_cmt;
      valid_d = valid_d & cmt_d;
    end
    if (enq_fire) begin
      valid_d[tail_idx] = 1'b1;
      cmt_d[tail_idx]   = 1'b0;
      tail_d            = tail_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      cmt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
        rob_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      cmt_q   <= cmt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (enq_fire) begin
        addr_q[tail_idx] <= sb.store_waddr[ADDR_WIDTH-1:2];
        data_q[tail_idx] <= sb.store_wdata;
        strb_q[tail_idx] <= enq_strb;
        rob_q[tail_idx]  <= sb.store_rob_id;
      end
    end
  end

  // Scan oldest to youngest; the last match seen is the youngest store to that word.
  logic fwd_match;
`ifdef STORE_BUFFER_FWD_EN
  logic                  fwd_cover;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic                  unused_ok;
  assign unused_ok = ^sb.ld_addr[1:0];

  always_comb begin
    fwd_match = 1'b0;
    fwd_cover = 1'b0;
    fwd_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[age_idx(head_idx, i)] &&
          addr_q[age_idx(head_idx, i)] == sb.ld_addr[ADDR_WIDTH-1:2]) begin
        fwd_match = 1'b1;
        fwd_cover = (sb.ld_strb & ~strb_q[age_idx(head_idx, i)]) == 4'b0000;
        fwd_data  = data_q[age_idx(head_idx, i)];
      end
    end
  end

  assign sb.ld_fwd_hit   = fwd_match && fwd_cover;
  assign sb.ld_fwd_data  = (fwd_match && fwd_cover) ? fwd_data : '0;
  assign sb.ld_fwd_stall = fwd_match && !fwd_cover;
`else
  logic unused_ok;
  assign unused_ok = ^{sb.ld_addr[1:0], sb.ld_strb};

  always_comb begin
    fwd_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == sb.ld_addr[ADDR_WIDTH-1:2]) fwd_match = 1'b1;
    end
  end

  assign sb.ld_fwd_hit   = 1'b0;
  assign sb.ld_fwd_data  = '0;
  assign sb.ld_fwd_stall = fwd_match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: enqueue/commit/drain ordering, full, flush, stall hold, forwarding, reset.
// Memory writes are checked against an expected queue filled by the directed tests.
module tb_store_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = AW + DW + 4;

  logic clk;
  logic rst;

  store_buffer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROB_WIDTH(5), .DEPTH(8)) sb_if ();

  store_buffer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROB_WIDTH(5), .DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    sb_if.store_valid   = 1'b0;
    sb_if.store_waddr   = '0;
    sb_if.store_wdata   = '0;
    sb_if.store_funct3  = 3'b000;
    sb_if.store_rob_id  = '0;
    sb_if.commit_valid  = 1'b0;
    sb_if.commit_rob_id = '0;
    sb_if.flush         = 1'b0;
    sb_if.mem_ready     = 1'b0;
    sb_if.ld_addr       = 32'hFFFF_FFF0;
    sb_if.ld_strb       = 4'b0000;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] f3, input logic [4:0] rob);
    sb_if.store_valid  = 1'b1;
    sb_if.store_waddr  = a;
    sb_if.store_wdata  = d;
    sb_if.store_funct3 = f3;
    sb_if.store_rob_id = rob;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic [4:0] rob);
    drive_store(a, d, f3, rob);
    cyc();
    sb_if.store_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [4:0] rob);
    sb_if.commit_valid  = 1'b1;
    sb_if.commit_rob_id = rob;
    cyc();
    sb_if.commit_valid = 1'b0;
  endtask

  task automatic do_flush();
    sb_if.flush = 1'b1;
    cyc();
    sb_if.flush = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({a, d, s});
  endtask

  task automatic check_ld(input string tag, input logic hit, input logic [31:0] data, input logic stall);
    check({tag, "_hit"},   64'(sb_if.ld_fwd_hit),   64'(hit));
    check({tag, "_data"},  64'(sb_if.ld_fwd_data),  64'(data));
    check({tag, "_stall"}, 64'(sb_if.ld_fwd_stall), 64'(stall));
  endtask

  // Scoreboard: every accepted memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && sb_if.mem_wen && sb_if.mem_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(sb_if.mem_waddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(sb_if.mem_waddr), 64'(mon_e[EW-1 -: AW]));
        check("wr_data", 64'(sb_if.mem_wdata), 64'(mon_e[DW+3:4]));
        check("wr_strb", 64'(sb_if.mem_wstrb), 64'(mon_e[3:0]));
      end
    end
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    at_neg();
    check("rst_count",  64'(sb_if.count),       64'd0);
    check("rst_full",   64'(sb_if.full),        64'd0);
    check("rst_wen",    64'(sb_if.mem_wen),     64'd0);
    check("rst_waddr",  64'(sb_if.mem_waddr),   64'd0);
    check("rst_wdata",  64'(sb_if.mem_wdata),   64'd0);
    check("rst_wstrb",  64'(sb_if.mem_wstrb),   64'd0);
    check_ld("rst_ld", 1'b0, 32'h0, 1'b0);
    cyc();
    rst = 1'b0;
    cyc();

    // SB to 0x103 lands in lane 3 of word 0x100
    sb_if.mem_ready = 1'b1;
    enq(32'h103, 32'hAB00_0000, 3'b000, 5'd4);
    sb_if.ld_addr = 32'h100;
    sb_if.ld_strb = 4'b1000;
    at_neg();
    check("sb_count", 64'(sb_if.count), 64'd1);
    check("sb_wen_precommit", 64'(sb_if.mem_wen), 64'd0);
`ifdef STORE_BUFFER_FWD_EN
    check_ld("sb_ld", 1'b1, 32'hAB00_0000, 1'b0);
`else
    check_ld("sb_ld", 1'b0, 32'h0, 1'b1);
`endif
    sb_if.ld_addr = 32'hFFFF_FFF0;
    push_exp(32'h100, 32'hAB00_0000, 4'b1000);
    do_commit(5'd4);
    at_neg();
    check("sb_wen", 64'(sb_if.mem_wen), 64'd1);
    cyc();
    at_neg();
    check("sb_wen_after", 64'(sb_if.mem_wen), 64'd0);
    check("sb_count_after", 64'(sb_if.count), 64'd0);

    // Fill to full; ninth store is ignored
    sb_if.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      enq(32'h300 + 32'(4 * i), 32'h1000_0000 + 32'(i), 3'b010, 5'(8 + i));
    end
    at_neg();
    check("fill_full", 64'(sb_if.full), 64'd1);
    check("fill_count", 64'(sb_if.count), 64'd8);
    enq(32'h400, 32'hFFFF_FFFF, 3'b010, 5'd20);
    at_neg();
    check("ninth_count", 64'(sb_if.count), 64'd8);
    check("ninth_full", 64'(sb_if.full), 64'd1);
    push_exp(32'h300, 32'h1000_0000, 4'b1111);
    sb_if.mem_ready = 1'b1;
    do_commit(5'd8);
    at_neg();
    check("fill_wen", 64'(sb_if.mem_wen), 64'd1);
    cyc();
    at_neg();
    check("unfull_full", 64'(sb_if.full), 64'd0);
    check("unfull_count", 64'(sb_if.count), 64'd7);
    do_flush();
    at_neg();
    check("fill_flush_count", 64'(sb_if.count), 64'd0);

    // Commit 1; commit 2 with flush in the cycle entry 1 drains; entry 3 is discarded
    enq(32'h500, 32'h0101_0101, 3'b010, 5'd1);
    enq(32'h506, 32'h2222_0000, 3'b001, 5'd2);
    enq(32'h508, 32'h0000_0033, 3'b000, 5'd3);
    push_exp(32'h500, 32'h0101_0101, 4'b1111);
    push_exp(32'h504, 32'h2222_0000, 4'b1100);
    do_commit(5'd1);
    sb_if.commit_valid  = 1'b1;
    sb_if.commit_rob_id = 5'd2;
    sb_if.flush         = 1'b1;
    at_neg();
    check("flush_wen1", 64'(sb_if.mem_wen), 64'd1);
    check("flush_count3", 64'(sb_if.count), 64'd3);
    cyc();
    sb_if.commit_valid = 1'b0;
    sb_if.flush        = 1'b0;
    at_neg();
    check("flush_count1", 64'(sb_if.count), 64'd1);
    check("flush_wen2", 64'(sb_if.mem_wen), 64'd1);
    cyc();
    at_neg();
    check("flush_count0", 64'(sb_if.count), 64'd0);
    check("flush_wen0", 64'(sb_if.mem_wen), 64'd0);
    repeat (3) cyc();

    // Memory back-pressure holds the committed head
    sb_if.mem_ready = 1'b0;
    enq(32'h600, 32'hDEAD_BEEF, 3'b010, 5'd6);
    enq(32'h604, 32'h0000_0007, 3'b010, 5'd7);
    do_commit(5'd6);
    for (int i = 0; i < 5; i++) begin
      at_neg();
      check("hold_wen",   64'(sb_if.mem_wen),   64'd1);
      check("hold_waddr", 64'(sb_if.mem_waddr), 64'h600);
      check("hold_wdata", 64'(sb_if.mem_wdata), 64'hDEAD_BEEF);
      check("hold_wstrb", 64'(sb_if.mem_wstrb), 64'hF);
      check("hold_count", 64'(sb_if.count),     64'd2);
      cyc();
    end
    push_exp(32'h600, 32'hDEAD_BEEF, 4'b1111);
    sb_if.mem_ready = 1'b1;
    cyc();
    sb_if.mem_ready = 1'b0;
    at_neg();
    check("release_count", 64'(sb_if.count), 64'd1);
    check("release_wen", 64'(sb_if.mem_wen), 64'd0);
    do_flush();

    // Unsupported funct3 drains as a zero-strobe write with a word-aligned address
    sb_if.mem_ready = 1'b1;
    push_exp(32'h700, 32'h1234_5678, 4'b0000);
    enq(32'h701, 32'h1234_5678, 3'b111, 5'd9);
    do_commit(5'd9);
    at_neg();
    check("nop_wen", 64'(sb_if.mem_wen), 64'd1);
    check("nop_wstrb", 64'(sb_if.mem_wstrb), 64'd0);
    cyc();
    at_neg();
    check("nop_count", 64'(sb_if.count), 64'd0);

    // Forwarding lookup against an SW then an overlapping SH
    sb_if.mem_ready = 1'b0;
    enq(32'h200, 32'h1111_1111, 3'b010, 5'd10);
    enq(32'h202, 32'h2222_0000, 3'b001, 5'd11);
    sb_if.ld_addr = 32'h200;
    sb_if.ld_strb = 4'b1100;
    at_neg();
`ifdef STORE_BUFFER_FWD_EN
    check_ld("fwd_hi", 1'b1, 32'h2222_0000, 1'b0);
`else
    check_ld("fwd_hi", 1'b0, 32'h0, 1'b1);
`endif
    sb_if.ld_strb = 4'b0011;
    at_neg();
    check_ld("fwd_lo", 1'b0, 32'h0, 1'b1);
    sb_if.ld_addr = 32'h204;
    sb_if.ld_strb = 4'b1111;
    at_neg();
    check_ld("fwd_miss", 1'b0, 32'h0, 1'b0);
    do_flush();
    sb_if.ld_addr = 32'h200;
    at_neg();
    check_ld("fwd_flushed", 1'b0, 32'h0, 1'b0);
    check("fwd_flush_count", 64'(sb_if.count), 64'd0);
    sb_if.ld_addr = 32'hFFFF_FFF0;

    // Enqueue during flush is dropped; drain plus enqueue leaves count unchanged
    sb_if.mem_ready = 1'b1;
    drive_store(32'h900, 32'h9999_9999, 3'b010, 5'd14);
    sb_if.flush = 1'b1;
    cyc();
    sb_if.flush       = 1'b0;
    sb_if.store_valid = 1'b0;
    at_neg();
    check("flush_enq_count", 64'(sb_if.count), 64'd0);
    enq(32'h800, 32'h0000_BEEF, 3'b010, 5'd12);
    push_exp(32'h800, 32'h0000_BEEF, 4'b1111);
    do_commit(5'd12);
    drive_store(32'h804, 32'h0000_CAFE, 3'b010, 5'd13);
    at_neg();
    check("both_wen", 64'(sb_if.mem_wen), 64'd1);
    check("both_count_pre", 64'(sb_if.count), 64'd1);
    cyc();
    sb_if.store_valid = 1'b0;
    at_neg();
    check("both_count_post", 64'(sb_if.count), 64'd1);
    check("both_wen_post", 64'(sb_if.mem_wen), 64'd0);
    do_flush();

    // Asynchronous reset while a committed head is waiting
    sb_if.mem_ready = 1'b0;
    enq(32'hA00, 32'hA0A0_A0A0, 3'b010, 5'd15);
    enq(32'hA04, 32'hA1A1_A1A1, 3'b010, 5'd16);
    enq(32'hA08, 32'hA2A2_A2A2, 3'b010, 5'd17);
    do_commit(5'd15);
    at_neg();
    check("mid_wen", 64'(sb_if.mem_wen), 64'd1);
    check("mid_count", 64'(sb_if.count), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_count", 64'(sb_if.count), 64'd0);
    check("arst_wen", 64'(sb_if.mem_wen), 64'd0);
    check("arst_full", 64'(sb_if.full), 64'd0);
    check("arst_waddr", 64'(sb_if.mem_waddr), 64'd0);
    cyc();
    rst = 1'b0;
    at_neg();
    check("post_rst_count", 64'(sb_if.count), 64'd0);
    check("post_rst_wen", 64'(sb_if.mem_wen), 64'd0);
    repeat (2) cyc();

    // Final report
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
